// File: rtl/serpent_xts_pkg.sv
// Shared XTS definitions: FSM encoding, the XTS reduction polynomial and the
// GF(2^128) multiply-by-alpha step used by both encrypt and decrypt wrappers.
package serpent_xts_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_TWEAK_CALC  = 3'd1,
        S_WAIT_DATA   = 3'd2,
        S_DATA_CIPHER = 3'd3,
        S_EMIT        = 3'd4
    } xts_state_e;

    localparam logic [127:0] XTS_GF_POLY = 128'h87;

    // Vector is an integer with bit0 as LSB; byte-order swaps happen outside.
    function automatic logic [127:0] gf128_mul_alpha(input logic [127:0] t);
        return {t[126:0], 1'b0} ^ (t[127] ? XTS_GF_POLY : 128'h0);
    endfunction

endpackage

// File: rtl/serpent_encrypt_top.sv
// Iterative Serpent-256 encryption core: one round per cycle with an on-the-fly
// key schedule. Words are little-endian within the ports (x0 = data[31:0]).
module serpent_encrypt_top (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_key_valid,
    input  logic [255:0] i_key,
    input  logic         i_enable,
    input  logic [127:0] i_data,
    output logic [127:0] o_data,
    output logic         o_data_valid
);

    localparam logic [31:0] PHI = 32'h9e3779b9;
    localparam logic [63:0] SBOX [8] = '{
        64'hC90724DEB56A1F83, 64'h43D68EB1A50972CF,
        64'h25B04E1DFAC39768, 64'hE57A421D369C8BF0,
        64'hD7E9A4526B0C38F1, 64'h176D8E30C9A4B25F,
        64'h0A3DF19EB6485C27, 64'h6539AC47B28E0FD1
    };

    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] n);
        return (v << n) | (v >> (6'd32 - {1'b0, n}));
    endfunction

    // Bitsliced S-box: bit b of the four words forms one nibble.
    function automatic logic [127:0] sbox_slice(input logic [2:0] sel, input logic [127:0] x);
        logic [127:0] y;
        logic [63:0]  tbl;
        logic [3:0]   n;
        logic [3:0]   s;
        tbl = SBOX[sel];
        y   = 128'h0;
        for (int b = 0; b < 32; b++) begin
            n = {x[96+b], x[64+b], x[32+b], x[b]};
            s = tbl[{n, 2'b00} +: 4];
            y[b]    = s[0];
            y[32+b] = s[1];
            y[64+b] = s[2];
            y[96+b] = s[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lin_tf(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = x;
        a = rol32(a, 5'd13);
        c = rol32(c, 5'd3);
        b = b ^ a ^ c;
        d = d ^ c ^ (a << 3);
        b = rol32(b, 5'd1);
        d = rol32(d, 5'd7);
        a = a ^ b ^ d;
        c = c ^ d ^ (b << 7);
        a = rol32(a, 5'd5);
        c = rol32(c, 5'd22);
        return {d, c, b, a};
    endfunction

    // Next four prekeys from the sliding window of the previous eight.
    function automatic logic [127:0] prekeys(input logic [255:0] win, input logic [5:0] rnd);
        logic [31:0] w [12];
        for (int k = 0; k < 8; k++) w[k] = win[32*k +: 32];
        for (int k = 0; k < 4; k++) begin
            w[8+k] = rol32(w[k] ^ w[k+3] ^ w[k+5] ^ w[k+7] ^ PHI ^ {24'd0, rnd, k[1:0]}, 5'd11);
        end
        return {w[11], w[10], w[9], w[8]};
    endfunction

    logic [255:0] win_r;
    logic [127:0] blk_r;
    logic [5:0]   round_r;
    logic         busy_r;
    logic [127:0] pk_s;
    logic [127:0] rk_s;
    logic [127:0] mix_s;
    logic [127:0] nxt_s;

    // Round key and round function for the current round.
    always_comb begin
        pk_s  = prekeys(win_r, round_r);
        rk_s  = sbox_slice(3'd3 - round_r[2:0], pk_s);
        mix_s = sbox_slice(round_r[2:0], blk_r ^ rk_s);
        if (round_r == 6'd31) begin
            nxt_s = mix_s;
        end else begin
            nxt_s = lin_tf(mix_s);
        end
    end

    // Load on enable, 33 key-mixing steps, then a one-cycle result pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            win_r        <= 256'h0;
            blk_r        <= 128'h0;
            round_r      <= 6'd0;
            busy_r       <= 1'b0;
            o_data       <= 128'h0;
            o_data_valid <= 1'b0;
        end else if (!i_enable || !i_key_valid) begin
            busy_r       <= 1'b0;
            o_data_valid <= 1'b0;
        end else if (!busy_r) begin
            o_data_valid <= 1'b0;
            if (!o_data_valid) begin
                busy_r  <= 1'b1;
                round_r <= 6'd0;
                blk_r   <= i_data;
                win_r   <= i_key;
            end
        end else begin
            win_r   <= {pk_s, win_r[255:128]};
            round_r <= round_r + 6'd1;
            if (round_r == 6'd32) begin
                o_data       <= blk_r ^ rk_s;
                o_data_valid <= 1'b1;
                busy_r       <= 1'b0;
            end else begin
                blk_r <= nxt_s;
            end
        end
    end

endmodule

// File: rtl/serpent_xts_en.sv
// XTS-mode Serpent-256 sector encryptor: tweak from key2/sector number,
// per-block whitening with the tweak, tweak advanced by alpha after each block.
module serpent_xts_en
    import serpent_xts_pkg::*;
#(
    parameter int BLOCKS_PER_SECTOR = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_master_key_valid,
    input  logic [511:0] i_key,
    input  logic         i_start,
    input  logic [127:0] i_sector,
    input  logic         i_data_valid,
    input  logic [127:0] i_data,
    output logic         o_ready,
    output logic [127:0] o_data,
    output logic         o_data_valid,
    output logic         o_sector_done,
    output logic         o_busy
);

    localparam int CNT_W = $clog2(BLOCKS_PER_SECTOR + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCKS_PER_SECTOR - 1);

    xts_state_e   state_r;
    logic [255:0] key1_r;
    logic [255:0] key2_r;
    logic [127:0] sector_r;
    logic [127:0] tweak_r;
    logic [127:0] din_r;
    logic [CNT_W-1:0] cnt_r;
    logic         tweak_en_r;
    logic         data_en_r;
    logic [127:0] tw_out_s;
    logic         tw_valid_s;
    logic [127:0] dc_out_s;
    logic         dc_valid_s;

    assign o_ready = (state_r == S_WAIT_DATA);
    assign o_busy  = (state_r != S_IDLE);

    serpent_encrypt_top tweak_cipher (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_key_valid  (i_master_key_valid),
        .i_key        (key2_r),
        .i_enable     (tweak_en_r),
        .i_data       (sector_r),
        .o_data       (tw_out_s),
        .o_data_valid (tw_valid_s)
    );

    serpent_encrypt_top data_cipher (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_key_valid  (i_master_key_valid),
        .i_key        (key1_r),
        .i_enable     (data_en_r),
        .i_data       (din_r),
        .o_data       (dc_out_s),
        .o_data_valid (dc_valid_s)
    );

    // Sector sequencing FSM; a key-valid drop in any active state aborts silently.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r       <= S_IDLE;
            key1_r        <= 256'h0;
            key2_r        <= 256'h0;
            sector_r      <= 128'h0;
            tweak_r       <= 128'h0;
            din_r         <= 128'h0;
            cnt_r         <= '0;
            tweak_en_r    <= 1'b0;
            data_en_r     <= 1'b0;
            o_data        <= 128'h0;
            o_data_valid  <= 1'b0;
            o_sector_done <= 1'b0;
        end else begin
            o_data_valid  <= 1'b0;
            o_sector_done <= 1'b0;
            if (state_r != S_IDLE && !i_master_key_valid) begin
                state_r    <= S_IDLE;
                tweak_en_r <= 1'b0;
                data_en_r  <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (i_start && i_master_key_valid) begin
                            key1_r     <= i_key[511:256];
                            key2_r     <= i_key[255:0];
                            sector_r   <= i_sector;
                            cnt_r      <= '0;
                            tweak_en_r <= 1'b1;
                            state_r    <= S_TWEAK_CALC;
                        end
                    end
                    S_TWEAK_CALC: begin
                        if (tw_valid_s) begin
                            tweak_r    <= tw_out_s;
                            tweak_en_r <= 1'b0;
                            state_r    <= S_WAIT_DATA;
                        end
                    end
                    S_WAIT_DATA: begin
                        if (i_data_valid) begin
                            din_r     <= i_data ^ tweak_r;
                            data_en_r <= 1'b1;
                            state_r   <= S_DATA_CIPHER;
                        end
                    end
                    S_DATA_CIPHER: begin
                        if (dc_valid_s) begin
                            o_data        <= dc_out_s ^ tweak_r;
                            data_en_r     <= 1'b0;
                            o_data_valid  <= 1'b1;
                            o_sector_done <= (cnt_r == LAST_IDX);
                            state_r       <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        tweak_r <= gf128_mul_alpha(tweak_r);
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= (cnt_r == LAST_IDX) ? S_IDLE : S_WAIT_DATA;
                    end
                    default: begin
                        state_r    <= S_IDLE;
                        tweak_en_r <= 1'b0;
                        data_en_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serpent_xts_en.sv
// Self-checking bench for serpent_xts_en against an array-based Serpent/XTS model.
module tb_serpent_xts_en;
    import serpent_xts_pkg::*;

    logic         clk;
    logic         rstn;
    logic         key_valid;
    logic [511:0] key;
    logic         start;
    logic [127:0] sector;
    logic         data_valid;
    logic [127:0] data;
    logic         ready, odv, done, busy;
    logic [127:0] odata;
    logic         ready1, odv1, done1, busy1;
    logic [127:0] odata1;
    logic         dut1_on;

    int checks;
    int errors;
    logic [127:0] pts   [4];
    logic [127:0] exp_c [4];

    int SB [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    serpent_xts_en #(.BLOCKS_PER_SECTOR(4)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_master_key_valid(key_valid), .i_key(key),
        .i_start(start), .i_sector(sector), .i_data_valid(data_valid), .i_data(data),
        .o_ready(ready), .o_data(odata), .o_data_valid(odv), .o_sector_done(done), .o_busy(busy)
    );

    serpent_xts_en #(.BLOCKS_PER_SECTOR(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_master_key_valid(key_valid), .i_key(key),
        .i_start(start && dut1_on), .i_sector(sector), .i_data_valid(data_valid), .i_data(data),
        .o_ready(ready1), .o_data(odata1), .o_data_valid(odv1), .o_sector_done(done1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] m_sbox(input int s, input logic [127:0] x);
        logic [127:0] y;
        int n, v;
        y = '0;
        for (int b = 0; b < 32; b++) begin
            n = 8 * int'(x[96+b]) + 4 * int'(x[64+b]) + 2 * int'(x[32+b]) + int'(x[b]);
            v = SB[s][n];
            y[b]    = v[0];
            y[32+b] = v[1];
            y[64+b] = v[2];
            y[96+b] = v[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] m_lt(input logic [127:0] x);
        logic [31:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = x[32*i +: 32];
        v[0] = rotl(v[0], 13);
        v[2] = rotl(v[2], 3);
        v[1] = v[1] ^ v[0] ^ v[2];
        v[3] = v[3] ^ v[2] ^ (v[0] << 3);
        v[1] = rotl(v[1], 1);
        v[3] = rotl(v[3], 7);
        v[0] = v[0] ^ v[1] ^ v[3];
        v[2] = v[2] ^ v[3] ^ (v[1] << 7);
        v[0] = rotl(v[0], 5);
        v[2] = rotl(v[2], 22);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    // Full key schedule up front, then 32 rounds.
    function automatic logic [127:0] m_enc(input logic [255:0] k, input logic [127:0] pt);
        logic [31:0]  w  [140];
        logic [127:0] rk [33];
        logic [127:0] x;
        for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
        for (int i = 8; i < 140; i++)
            w[i] = rotl(w[i-8] ^ w[i-5] ^ w[i-3] ^ w[i-1] ^ 32'h9e3779b9 ^ 32'(i - 8), 11);
        for (int r = 0; r < 33; r++)
            rk[r] = m_sbox((35 - r) % 8, {w[4*r+11], w[4*r+10], w[4*r+9], w[4*r+8]});
        x = pt;
        for (int r = 0; r < 32; r++) begin
            x = m_sbox(r % 8, x ^ rk[r]);
            if (r < 31) x = m_lt(x);
        end
        return x ^ rk[32];
    endfunction

    function automatic logic [127:0] m_alpha(input logic [127:0] t);
        logic [128:0] p;
        p = {t, 1'b0};
        if (p[128]) p = p ^ {1'b1, 128'h87};
        return p[127:0];
    endfunction

    task automatic model_sector(input logic [511:0] k, input logic [127:0] sec);
        logic [127:0] t;
        t = m_enc(k[255:0], sec);
        for (int j = 0; j < 4; j++) begin
            exp_c[j] = m_enc(k[511:256], pts[j] ^ t) ^ t;
            t = m_alpha(t);
        end
    endtask

    task automatic rand_pts();
        for (int j = 0; j < 4; j++) pts[j] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_key(output logic [511:0] k);
        for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
    endtask

    task automatic run_sector(input logic [511:0] k, input logic [127:0] sec, input int gap,
                              input bit poke, input int abort_at);
        int n;
        bit ok;
        model_sector(k, sec);
        key = k; sector = sec; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_low_tweak", ready, 0);
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!ready && n < 300) begin @(negedge clk); n++; end
            chk("ready_seen", ready, 1);
            if (poke && j == 1) begin
                sector = ~sec; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("start_ignored_busy", ready, 1);
            end
            ok = 1'b1;
            repeat (gap) begin @(negedge clk); if (!ready) ok = 1'b0; end
            if (gap > 0) chk("ready_hold", ok, 1);
            data = pts[j]; data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0; data = ~pts[j];
            chk("ready_low_cipher", ready, 0);
            if (j == abort_at) begin
                repeat (5) @(negedge clk);
                key_valid = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_ready", ready, 0);
                ok = 1'b1;
                repeat (60) begin @(negedge clk); if (odv || done) ok = 1'b0; end
                chk("abort_no_valid", ok, 1);
                chk("abort_hold", odata, exp_c[j-1]);
                key_valid = 1'b1;
                return;
            end
            n = 0;
            while (!odv && n < 300) begin @(negedge clk); n++; end
            chk("valid_seen", odv, 1);
            chk("cipher", odata, exp_c[j]);
            chk("sector_done", done, (j == 3));
            if (j == 0 && dut1_on) begin
                chk("bps1_valid", odv1, 1);
                chk("bps1_cipher", odata1, exp_c[0]);
                chk("bps1_done", done1, 1);
            end
            @(negedge clk);
            chk("valid_pulse", odv, 0);
            if (j == 0 && dut1_on) chk("bps1_idle", busy1, 0);
        end
        chk("idle_after", busy, 0);
    endtask

    logic [511:0] rk1;
    logic [511:0] rk2;

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0; key_valid = 1'b0; key = '0; start = 1'b0; sector = '0;
        data_valid = 1'b0; data = '0; dut1_on = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_data", odata, 0);
        chk("rst_valid", odv, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1; key_valid = 1'b1;
        @(negedge clk);

        chk("gf_msb", gf128_mul_alpha(128'h80000000000000000000000000000000), 128'h87);
        chk("gf_one", gf128_mul_alpha(128'h1), 128'h2);
        chk("gf_c0", gf128_mul_alpha(128'hC0000000000000000000000000000000),
            128'h80000000000000000000000000000087);

        key_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_no_key", busy, 0);
        key_valid = 1'b1;

        for (int j = 0; j < 4; j++) pts[j] = '0;
        dut1_on = 1'b1;
        run_sector(512'h0, 128'h0, 0, 1'b0, -1);
        dut1_on = 1'b0;
        run_sector(512'h0, 128'h0, 10, 1'b0, -1);

        rand_pts(); rand_key(rk1);
        run_sector(rk1, 128'h1234, int'($urandom_range(0, 3)), 1'b1, -1);

        rand_pts(); rand_key(rk2);
        run_sector(rk2, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 2);
        rand_pts();
        run_sector(rk2, 128'h55, 1, 1'b0, -1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("tweak_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_data", odata, 0);
        chk("mid_rst_valid", odv, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rand_pts(); rand_key(rk1);
        run_sector(rk1, 128'hABCD, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
